unidade_busca: RTL and testbench
================================

UNIDADE_BUSCA -- requirements
Module: unidade_busca

Interface
REQ-001 Parameter PC_W, default 8: width of the program counter and instruction-memory address.
REQ-002 Parameter INSTR_W, default 16: instruction width; opcode is bits [INSTR_W-1:INSTR_W-4].
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 EscCP  input  1  unconditional PC write from the control unit.
REQ-006 EscCondCP  input  1  conditional PC write, qualified by zero.
REQ-007 zero  input  1  ULA zero flag.
REQ-008 FonteCP  input  2  PC source select.
REQ-009 ula_res  input  PC_W  ULA result, the branch target.
REQ-010 mem_req  output  1  instruction-memory read request.
REQ-011 mem_addr  output  PC_W  instruction-memory address.
REQ-012 mem_ack  input  1  memory read complete; mem_dado is valid in the same cycle.
REQ-013 mem_dado  input  INSTR_W  instruction word from memory.
REQ-014 pc  output  PC_W  current PC.
REQ-015 instr  output  INSTR_W  instruction register.
REQ-016 opcode  output  4  instr[INSTR_W-1:INSTR_W-4], which feeds the control unit.
REQ-017 instr_valida  output  1  one-cycle pulse when instr is updated.
REQ-018 ocupado  output  1  high while no executable instruction is held.

Function
REQ-019 The FSM SHALL have states OCIOSO, BUSCA and EXEC, plus PAUSA when the macro of REQ-032 is defined.
REQ-020 OCIOSO SHALL go to BUSCA on the first clock edge after reset deasserts.
REQ-021 In BUSCA, mem_req SHALL be 1 (Moore output) and mem_addr SHALL equal pc; mem_addr SHALL equal pc in every state.
REQ-022 In BUSCA, mem_ack=1 SHALL load instr from mem_dado, assert instr_valida on the next cycle only, and move the FSM to EXEC.
REQ-023 mem_ack SHALL be ignored in OCIOSO, EXEC and PAUSA.
REQ-024 In EXEC, a PC write occurs when EscCP=1, or when EscCondCP=1 and zero=1.
REQ-025 On a PC write, the FSM SHALL go to BUSCA; otherwise it SHALL stay in EXEC.
REQ-026 On a PC write, the next pc by FonteCP SHALL be:
  - 00: pc+1, modulo 2^PC_W, so 0xFF wraps to 0x00.
  - 01: ula_res.
  - 10: {zeros, instr[PC_W-1:0]} (jump immediate).
  - 11: pc unchanged; the refetch still happens.
REQ-027 PC write requests in OCIOSO, BUSCA and PAUSA SHALL be ignored.
REQ-028 If mem_ack and EscCP arrive in the same cycle in BUSCA, only the ack SHALL take effect.
REQ-029 ocupado SHALL be 1 in every state except EXEC.
REQ-030 Fetch latency from entering BUSCA SHALL be (ack cycles + 1) until the instr update and EXEC.

Reset
REQ-031 Asserting reset, even mid-fetch, SHALL immediately force:
  - state OCIOSO;
  - pc=0, instr=0, hence opcode=0;
  - mem_req=0, instr_valida=0, ocupado=1;
  - erro_busca=0 and timeout counter=0 when REQ-032 is enabled.
  A pending ack is discarded.

Configuration
REQ-032 With UNIDADE_BUSCA_TIMEOUT_EN defined, the block SHALL add:
  - output erro_busca (1 bit, sticky until reset);
  - a 4-bit counter of BUSCA cycles without mem_ack.
REQ-033 When that counter reaches 15:
  - erro_busca SHALL be set;
  - the FSM SHALL spend one cycle in PAUSA with mem_req=0;
  - the counter SHALL clear and BUSCA SHALL be re-entered with the same pc.
REQ-034 Without the macro, there SHALL be no erro_busca port and no PAUSA state, and BUSCA SHALL wait indefinitely.

Structure
REQ-035 A shared package SHALL hold:
  - the state encoding typedef;
  - FonteCP codes FCP_INC=2'b00, FCP_ULA=2'b01, FCP_JUMP=2'b10, FCP_HOLD=2'b11;
  - the opcode field position constants.
  The control unit uses the same FonteCP codes.
REQ-036 The block SHALL contain one sub-module, reg_cp: the PC register with next-PC mux and write enable. The FSM and instruction register stay in unidade_busca.

Verification
REQ-037 Reset release, then mem_ack one cycle after mem_req with mem_dado=16'hB012. Required: instr=16'hB012, opcode=4'hB, one-cycle instr_valida pulse, ocupado=0.
REQ-038 pc=0x05 in EXEC, EscCP=1, FonteCP=00. Required: pc=0x06 next cycle, mem_req=1, mem_addr=0x06. Repeat with pc=0xFF: pc=0x00.
REQ-039 EscCondCP=1, FonteCP=01, ula_res=0x40. With zero=0: pc unchanged and FSM stays in EXEC. With zero=1: pc=0x40.
REQ-040 instr=16'hB023, EscCP=1, FonteCP=10. Required: pc=0x23. Separately, EscCP=1 with mem_ack in the same BUSCA cycle: pc unchanged.
REQ-041 Reset asserted while mem_req=1 and before ack. Required: mem_req=0, pc=0, instr=0 immediately.
REQ-042 With UNIDADE_BUSCA_TIMEOUT_EN and no ack for 15 cycles. Required: erro_busca=1, one cycle of mem_req=0, then mem_req=1 with the same mem_addr.

Source files
------------

// File: rtl/unidade_busca_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | unidade_busca_pkg                                                          |
// | Shared types and codes for the fetch unit and the control unit.            |
// | Optional macro: UNIDADE_BUSCA_TIMEOUT_EN (adds the PAUSA state).           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package unidade_busca_pkg;

`ifdef UNIDADE_BUSCA_TIMEOUT_EN
    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        BUSCA  = 2'd1,
        EXEC   = 2'd2,
        PAUSA  = 2'd3
    } estado_t;
`else
    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        BUSCA  = 2'd1,
        EXEC   = 2'd2
    } estado_t;
`endif

    // PC source codes, also driven by the control unit
    localparam logic [1:0] FCP_INC  = 2'b00;
    localparam logic [1:0] FCP_ULA  = 2'b01;
    localparam logic [1:0] FCP_JUMP = 2'b10;
    localparam logic [1:0] FCP_HOLD = 2'b11;

    localparam int OPCODE_W = 4;

    // Number of BUSCA cycles without ack that trips the fetch timeout
    localparam logic [3:0] c_TMO_MAX = 4'd15;

    function automatic int opcode_lsb(input int instr_w);
        return instr_w - OPCODE_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/unidade_busca_reg_cp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_cp                                                                     |
// | Program counter register with next-PC source mux and write enable.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module reg_cp
    import unidade_busca_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_we,
    input  logic [1:0]      i_fonte,
    input  logic [PC_W-1:0] i_ula,
    input  logic [PC_W-1:0] i_imm,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_prox;

    always_comb begin
        w_prox = r_pc;
        case (i_fonte)
            FCP_INC:  w_prox = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
            FCP_ULA:  w_prox = i_ula;
            FCP_JUMP: w_prox = i_imm;
            FCP_HOLD: w_prox = r_pc;
            default:  w_prox = r_pc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
        end else if (i_we) begin
            r_pc <= w_prox;
        end
    end

    assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/unidade_busca.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | unidade_busca                                                              |
// | Instruction fetch unit: fetch FSM, instruction register and PC update.    |
// | Optional macro: UNIDADE_BUSCA_TIMEOUT_EN (fetch timeout, erro_busca).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module unidade_busca
    import unidade_busca_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               EscCP,
    input  logic               EscCondCP,
    input  logic               zero,
    input  logic [1:0]         FonteCP,
    input  logic [PC_W-1:0]    ula_res,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_dado,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic               instr_valida,
`ifdef UNIDADE_BUSCA_TIMEOUT_EN
    output logic               erro_busca,
`endif
    output logic               ocupado
);

    localparam int c_OPC_LSB = opcode_lsb(INSTR_W);

    estado_t              r_estado;
    estado_t              w_prox;
    logic [INSTR_W-1:0]   r_instr;
    logic                 r_valida;
    logic [PC_W-1:0]      w_pc;
    logic                 w_esc_pc;
    logic                 w_carrega;

`ifdef UNIDADE_BUSCA_TIMEOUT_EN
    logic [3:0]           r_cnt;
    logic                 r_erro;
    logic                 w_timeout;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox;
        end
    end

    always_comb begin
        w_prox    = r_estado;
        mem_req   = 1'b0;
        ocupado   = 1'b1;
        w_esc_pc  = 1'b0;
        w_carrega = 1'b0;
`ifdef UNIDADE_BUSCA_TIMEOUT_EN
        w_timeout = 1'b0;
`endif
        case (r_estado)
            OCIOSO: begin
                w_prox = BUSCA;
            end
            BUSCA: begin
                mem_req = 1'b1;
                // An ack wins over any PC write request in the same cycle
                if (mem_ack) begin
                    w_carrega = 1'b1;
                    w_prox    = EXEC;
                end
`ifdef UNIDADE_BUSCA_TIMEOUT_EN
                else if (r_cnt == (c_TMO_MAX - 4'd1)) begin
                    w_timeout = 1'b1;
                    w_prox    = PAUSA;
                end
`endif
            end
            EXEC: begin
                ocupado = 1'b0;
                if (EscCP || (EscCondCP && zero)) begin
                    w_esc_pc = 1'b1;
                    w_prox   = BUSCA;
                end
            end
`ifdef UNIDADE_BUSCA_TIMEOUT_EN
            PAUSA: begin
                w_prox = BUSCA;
            end
`endif
            default: begin
                w_prox = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr  <= '0;
            r_valida <= 1'b0;
        end else begin
            r_valida <= w_carrega;
            if (w_carrega) begin
                r_instr <= mem_dado;
            end
        end
    end

`ifdef UNIDADE_BUSCA_TIMEOUT_EN
    // Counts consecutive BUSCA cycles without ack; cleared everywhere else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= 4'd0;
            r_erro <= 1'b0;
        end else begin
            if ((r_estado == BUSCA) && !mem_ack && !w_timeout) begin
                r_cnt <= r_cnt + 4'd1;
            end else begin
                r_cnt <= 4'd0;
            end
            if (w_timeout) begin
                r_erro <= 1'b1;
            end
        end
    end

    assign erro_busca = r_erro;
`endif

    reg_cp #(
        .PC_W (PC_W)
    ) u_reg_cp (
        .clk     (clk),
        .rst     (reset),
        .i_we    (w_esc_pc),
        .i_fonte (FonteCP),
        .i_ula   (ula_res),
        .i_imm   (r_instr[PC_W-1:0]),
        .o_pc    (w_pc)
    );

    assign pc           = w_pc;
    assign mem_addr     = w_pc;
    assign instr        = r_instr;
    assign opcode       = r_instr[c_OPC_LSB +: OPCODE_W];
    assign instr_valida = r_valida;

endmodule
`default_nettype wire

// File: tb/tb_unidade_busca.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_unidade_busca                                                           |
// | Table-driven self-checking bench for unidade_busca.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_unidade_busca;

    logic        clk;
    logic        reset;
    logic        EscCP;
    logic        EscCondCP;
    logic        zero;
    logic [1:0]  FonteCP;
    logic [7:0]  ula_res;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_dado;
    logic [7:0]  pc;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic        instr_valida;
    logic        ocupado;
`ifdef UNIDADE_BUSCA_TIMEOUT_EN
    logic        erro_busca;
`endif

    int errors = 0;
    int checks = 0;

    unidade_busca #(
        .PC_W    (8),
        .INSTR_W (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .EscCP        (EscCP),
        .EscCondCP    (EscCondCP),
        .zero         (zero),
        .FonteCP      (FonteCP),
        .ula_res      (ula_res),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_dado     (mem_dado),
        .pc           (pc),
        .instr        (instr),
        .opcode       (opcode),
        .instr_valida (instr_valida),
`ifdef UNIDADE_BUSCA_TIMEOUT_EN
        .erro_busca   (erro_busca),
`endif
        .ocupado      (ocupado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        esc;
        logic        cond;
        logic        z;
        logic [1:0]  fcp;
        logic [7:0]  ula;
        logic        ack;
        logic [15:0] dado;
        logic [7:0]  e_pc;
        logic        e_req;
        logic [15:0] e_instr;
        logic        e_val;
        logic        e_ocup;
    } vec_t;

    vec_t tv [22];

    function automatic vec_t mk(input logic esc, input logic cond, input logic z,
                                input logic [1:0] fcp, input logic [7:0] ula,
                                input logic ack, input logic [15:0] dado,
                                input logic [7:0] e_pc, input logic e_req,
                                input logic [15:0] e_instr, input logic e_val,
                                input logic e_ocup);
        vec_t v;
        v.esc = esc; v.cond = cond; v.z = z; v.fcp = fcp; v.ula = ula;
        v.ack = ack; v.dado = dado; v.e_pc = e_pc; v.e_req = e_req;
        v.e_instr = e_instr; v.e_val = e_val; v.e_ocup = e_ocup;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        EscCP = 1'b0; EscCondCP = 1'b0; zero = 1'b0; FonteCP = 2'b00;
        ula_res = 8'h00; mem_ack = 1'b0; mem_dado = 16'h0000;
    endtask

    initial begin
        //            esc cond z  fcp    ula    ack dado      | pc    req instr    val ocup
        tv[0]  = mk(0, 0, 0, 2'd0, 8'h00, 0, 16'h0000, 8'h00, 1, 16'h0000, 0, 1);
        tv[1]  = mk(0, 0, 0, 2'd0, 8'h00, 1, 16'hB012, 8'h00, 0, 16'hB012, 1, 0);
        tv[2]  = mk(0, 0, 0, 2'd0, 8'h00, 0, 16'h0000, 8'h00, 0, 16'hB012, 0, 0);
        tv[3]  = mk(0, 0, 0, 2'd0, 8'h00, 1, 16'h1234, 8'h00, 0, 16'hB012, 0, 0);
        tv[4]  = mk(1, 0, 0, 2'd1, 8'h05, 0, 16'h0000, 8'h05, 1, 16'hB012, 0, 1);
        tv[5]  = mk(0, 0, 0, 2'd0, 8'h00, 1, 16'h0000, 8'h05, 0, 16'h0000, 1, 0);
        tv[6]  = mk(1, 0, 0, 2'd0, 8'h00, 0, 16'h0000, 8'h06, 1, 16'h0000, 0, 1);
        tv[7]  = mk(1, 0, 0, 2'd0, 8'h00, 1, 16'hB023, 8'h06, 0, 16'hB023, 1, 0);
        tv[8]  = mk(0, 1, 0, 2'd1, 8'h40, 0, 16'h0000, 8'h06, 0, 16'hB023, 0, 0);
        tv[9]  = mk(0, 1, 1, 2'd1, 8'h40, 0, 16'h0000, 8'h40, 1, 16'hB023, 0, 1);
        tv[10] = mk(0, 0, 0, 2'd0, 8'h00, 1, 16'hB023, 8'h40, 0, 16'hB023, 1, 0);
        tv[11] = mk(1, 0, 0, 2'd2, 8'h00, 0, 16'h0000, 8'h23, 1, 16'hB023, 0, 1);
        tv[12] = mk(1, 0, 0, 2'd1, 8'h77, 0, 16'h0000, 8'h23, 1, 16'hB023, 0, 1);
        tv[13] = mk(0, 0, 0, 2'd0, 8'h00, 1, 16'h00FF, 8'h23, 0, 16'h00FF, 1, 0);
        tv[14] = mk(1, 0, 0, 2'd2, 8'h00, 0, 16'h0000, 8'hFF, 1, 16'h00FF, 0, 1);
        tv[15] = mk(0, 0, 0, 2'd0, 8'h00, 1, 16'h0000, 8'hFF, 0, 16'h0000, 1, 0);
        tv[16] = mk(1, 0, 0, 2'd0, 8'h00, 0, 16'h0000, 8'h00, 1, 16'h0000, 0, 1);
        tv[17] = mk(0, 0, 0, 2'd0, 8'h00, 1, 16'h5A5A, 8'h00, 0, 16'h5A5A, 1, 0);
        tv[18] = mk(1, 0, 0, 2'd3, 8'h99, 0, 16'h0000, 8'h00, 1, 16'h5A5A, 0, 1);
        tv[19] = mk(0, 1, 1, 2'd1, 8'h33, 0, 16'h0000, 8'h00, 1, 16'h5A5A, 0, 1);
        tv[20] = mk(0, 0, 0, 2'd0, 8'h00, 1, 16'h7001, 8'h00, 0, 16'h7001, 1, 0);
        tv[21] = mk(0, 0, 1, 2'd1, 8'h33, 0, 16'h0000, 8'h00, 0, 16'h7001, 0, 0);

        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 8'h00);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_opcode", opcode, 4'h0);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_val", instr_valida, 1'b0);
        chk("rst_ocup", ocupado, 1'b1);
`ifdef UNIDADE_BUSCA_TIMEOUT_EN
        chk("rst_erro", erro_busca, 1'b0);
`endif

        reset = 1'b0;
        step();
        chk("start_req", mem_req, 1'b1);
        chk("start_addr", mem_addr, 8'h00);

        for (int i = 0; i < 22; i++) begin
            EscCP = tv[i].esc; EscCondCP = tv[i].cond; zero = tv[i].z;
            FonteCP = tv[i].fcp; ula_res = tv[i].ula;
            mem_ack = tv[i].ack; mem_dado = tv[i].dado;
            step();
            chk($sformatf("v%0d_pc", i), pc, tv[i].e_pc);
            chk($sformatf("v%0d_addr", i), mem_addr, tv[i].e_pc);
            chk($sformatf("v%0d_req", i), mem_req, tv[i].e_req);
            chk($sformatf("v%0d_instr", i), instr, tv[i].e_instr);
            chk($sformatf("v%0d_opcode", i), opcode, tv[i].e_instr[15:12]);
            chk($sformatf("v%0d_val", i), instr_valida, tv[i].e_val);
            chk($sformatf("v%0d_ocup", i), ocupado, tv[i].e_ocup);
        end

        // Mid-fetch reset with an ack pending
        idle_inputs();
        EscCP = 1'b1;
        step();
        chk("mf_req", mem_req, 1'b1);
        chk("mf_pc", pc, 8'h01);
        idle_inputs();
        mem_ack = 1'b1; mem_dado = 16'h1111;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_req", mem_req, 1'b0);
        chk("arst_pc", pc, 8'h00);
        chk("arst_instr", instr, 16'h0000);
        chk("arst_val", instr_valida, 1'b0);
        chk("arst_ocup", ocupado, 1'b1);
        step();
        chk("arst_hold_req", mem_req, 1'b0);
        reset = 1'b0;
        step();
        chk("post_req", mem_req, 1'b1);
        chk("post_instr", instr, 16'h0000);
        chk("post_val", instr_valida, 1'b0);
        mem_ack = 1'b0;

`ifdef UNIDADE_BUSCA_TIMEOUT_EN
        for (int i = 1; i < 15; i++) begin
            step();
            chk($sformatf("tmo_wait%0d_req", i), mem_req, 1'b1);
            chk($sformatf("tmo_wait%0d_erro", i), erro_busca, 1'b0);
        end
        step();
        chk("tmo_pausa_req", mem_req, 1'b0);
        chk("tmo_pausa_erro", erro_busca, 1'b1);
        chk("tmo_pausa_addr", mem_addr, 8'h00);
        step();
        chk("tmo_rebusca_req", mem_req, 1'b1);
        chk("tmo_rebusca_addr", mem_addr, 8'h00);
        chk("tmo_sticky", erro_busca, 1'b1);
        mem_ack = 1'b1; mem_dado = 16'hC0DE;
        step();
        chk("tmo_ack_instr", instr, 16'hC0DE);
        chk("tmo_ack_erro", erro_busca, 1'b1);
        mem_ack = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
